// File: rtl/mp_adder_seq_if.sv
// Request/result bundle for the chunked wide adder: the requester drives operands and start,
// the sequencer returns busy/done and the registered result.
interface mp_adder_seq_if #(
  parameter int N = 4,
  parameter int K = 4
);
  localparam int W = N * K;

  logic         start;
  logic         sub;
  logic         ci;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  modport master (
    output start, sub, ci, a, b,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, sub, ci, a, b,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/mp_adder_seq.sv
// Wide add/subtract built from one N-bit ripple-carry adder reused over K cycles,
// least significant chunk first, with the carry held in a register between chunks.
module adder_rc #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic carry;

  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < N; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    co = carry;
  end
endmodule

module mp_adder_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mp_adder_seq_if.slave bus
);
  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   last;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  work_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;

  logic [W-1:0] a_shift;
  logic [W-1:0] b_shift;
  logic [W-1:0] chunk_mask;
  logic [W-1:0] work_next;
  logic [N-1:0] a_chunk;
  logic [N-1:0] b_chunk;
  logic [N-1:0] sum_chunk;
  logic         chunk_co;

  logic [W-1:0] s_reg;
  logic         co_reg;
  logic         ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // DONE behaves like IDLE for new requests, which allows back-to-back operations.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        last = (idx == LAST_IDX);
        if (last) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Current chunk selection and merge of the new sum chunk into the working value.
  always_comb begin
    a_shift    = a_reg >> (idx * N);
    b_shift    = b_reg >> (idx * N);
    a_chunk    = a_shift[N-1:0];
    b_chunk    = b_shift[N-1:0];
    chunk_mask = W'({N{1'b1}}) << (idx * N);
    work_next  = (work_reg & ~chunk_mask) | (W'(sum_chunk) << (idx * N));
  end

  adder_rc #(.N(N)) u_adder (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry_reg),
    .s  (sum_chunk),
    .co (chunk_co)
  );

  // Subtraction is folded into the capture: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      s_reg     <= '0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= bus.a;
        b_reg     <= bus.sub ? ~bus.b : bus.b;
        carry_reg <= bus.sub ? 1'b1 : bus.ci;
        idx       <= '0;
      end else if (state == RUN) begin
        work_reg  <= work_next;
        carry_reg <= chunk_co;
        idx       <= last ? '0 : idx + 1'b1;
      end
      if (last) begin
        s_reg   <= work_next;
        co_reg  <= chunk_co;
        ovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (work_next[W-1] != a_reg[W-1]);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.s    = s_reg;
  assign bus.co   = co_reg;
  assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_mp_adder_seq.sv
// Scoreboard bench for mp_adder_seq: stimulus pushes expected results, a negedge monitor
// pops and compares them whenever done is seen.
module tb_mp_adder_seq;
  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mp_adder_seq_if #(.N(N), .K(K)) bus ();

  mp_adder_seq #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic prevDone   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] beff;
    exp_t         e;
    beff  = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
    e.s   = full[W-1:0];
    e.co  = full[W];
    e.ovf = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Monitor: every done must match the oldest expectation and last exactly one cycle.
  always @(negedge clk) begin
    if (bus.done) begin
      checkOutput("done_pulse_width", 32'(prevDone), 32'd0);
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: actual=1 required=0");
      end else begin
        checkOutput("s",   32'(bus.s),   32'(expQ[0].s));
        checkOutput("co",  32'(bus.co),  32'(expQ[0].co));
        checkOutput("ovf", 32'(bus.ovf), 32'(expQ[0].ovf));
        void'(expQ.pop_front());
      end
    end
    prevDone <= bus.done;
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                               input logic ci, input exp_t e, input bit push);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    bus.ci    = ci;
    bus.start = 1'b1;
    if (push) expQ.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.sub   = 1'($urandom);
    bus.ci    = 1'($urandom);
  endtask

  task automatic waitDone(output int lat, output int busyCnt);
    lat     = 1;
    busyCnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busyCnt++;
    end
    if (!bus.done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_timeout: actual=no done after %0d cycles required=done", lat);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ovf);
    exp_t e;
    e.s = s; e.co = co; e.ovf = ovf;
    return e;
  endfunction

  initial begin
    int   lat, busyCnt, firstDone, secondDone;
    logic [W-1:0] ra, rb;
    logic rs, rc;

    bus.start = 1'b0; bus.sub = 1'b0; bus.ci = 1'b0; bus.a = '0; bus.b = '0;

    #12;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_s",    32'(bus.s),    32'd0);
    checkOutput("reset_co",   32'(bus.co),   32'd0);
    checkOutput("reset_ovf",  32'(bus.ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0, mk(16'h2233, 1'b0, 1'b0), 1'b1);
    waitDone(lat, busyCnt);
    checkOutput("latency", 32'(lat), 32'(K + 1));
    checkOutput("busy_cycles", 32'(busyCnt), 32'(K));

    applyStimulus(16'hFFFF, 16'h0000, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0), 1'b1);
    waitDone(lat, busyCnt);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1'b1);
    waitDone(lat, busyCnt);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1'b1);
    waitDone(lat, busyCnt);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, mk(16'h7FFF, 1'b1, 1'b1), 1'b1);
    waitDone(lat, busyCnt);

    // Start held for 10 cycles with changing operands: ops from cycle 0 and cycle 5 are taken.
    expQ.push_back(mk(16'h1212, 1'b0, 1'b0));
    expQ.push_back(mk(16'h6C6C, 1'b0, 1'b0));
    firstDone  = -1;
    secondDone = -1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      bus.a     = W'(16'h1111 * (k + 1));
      bus.b     = W'(16'h0101 * (k + 1));
      bus.sub   = 1'b0;
      bus.ci    = 1'b0;
      bus.start = (k < 10);
      if (bus.done) begin
        if (firstDone < 0) firstDone = k;
        else               secondDone = k;
      end
      if (firstDone >= 0 && !bus.done) checkOutput("held_result", 32'(bus.s), 32'h1212);
    end
    bus.start = 1'b0;
    checkOutput("first_done_cycle", 32'(firstDone), 32'd5);
    checkOutput("done_spacing", 32'(secondDone - firstDone), 32'd5);

    // Asynchronous reset two cycles into RUN abandons the operation.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b0);
    @(negedge clk);
    checkOutput("busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_s",    32'(bus.s),    32'd0);
    checkOutput("midrst_co",   32'(bus.co),   32'd0);
    checkOutput("midrst_ovf",  32'(bus.ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idle_after_reset", 32'(bus.busy), 32'd0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, mk(16'h0002, 1'b0, 1'b0), 1'b1);
    waitDone(lat, busyCnt);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rs, rc, model(ra, rb, rs, rc), 1'b1);
      waitDone(lat, busyCnt);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
